// File: rtl/bist_race_if.sv
// Handshake bundle between the race monitor and its BIST engines/host.
// The master side drives the run request and engine status; the slave (monitor) drives starts and the report.
interface bist_race_if #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_WIDTH = 1
);
  logic                        go;
  logic [NUM_CH-1:0]           ch_start;
  logic [NUM_CH-1:0]           ch_done;
  logic [NUM_CH-1:0]           ch_error;
  logic [NUM_CH*CNT_WIDTH-1:0] ch_cycles;
  logic [NUM_CH-1:0]           ch_fail;
  logic [NUM_CH-1:0]           ch_timeout;
  logic [IDX_WIDTH-1:0]        fastest_idx;
  logic                        fastest_valid;
  logic                        all_pass;
  logic                        busy;
  logic                        report_valid;

  modport master (
    output go, ch_done, ch_error,
    input  ch_start, ch_cycles, ch_fail, ch_timeout,
    input  fastest_idx, fastest_valid, all_pass, busy, report_valid
  );

  modport slave (
    input  go, ch_done, ch_error,
    output ch_start, ch_cycles, ch_fail, ch_timeout,
    output fastest_idx, fastest_valid, all_pass, busy, report_valid
  );
endinterface

// File: rtl/bist_race_monitor.sv
// Races NUM_CH BIST engines from a common start, latches per-channel latency/error/timeout,
// and presents a registered report SETTLE cycles after the race ends.
//
//   state     | meaning
//   ST_IDLE   | waiting for go after reset
//   ST_RUN    | engines started, cyc counting, capturing completions
//   ST_SETTLE | starts released, down-counting the settle window
//   ST_REPORT | report registered and held until the next go
module bist_race_monitor #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 5000,
  parameter int SETTLE    = 10,
  parameter int IDX_WIDTH = 1
) (
  input logic       clk,
  input logic       rst,
  bist_race_if.slave bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_WIDTH-1:0] TO_VAL      = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] TO_LAST     = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SETTLE, ST_REPORT} state_t;

  state_t                      state, state_nxt;
  logic [CNT_WIDTH-1:0]        cyc;
  logic [SW-1:0]               settle_cnt;
  logic [NUM_CH-1:0]           captured, cap_now, fail_q, tmo_q;
  logic [NUM_CH*CNT_WIDTH-1:0] cycles_q;
  logic [IDX_WIDTH-1:0]        fidx_q, best_idx;
  logic [CNT_WIDTH-1:0]        best_val;
  logic                        fval_q, pass_q, rv_q, best_found;
  logic                        start_run, all_done, tmo_end, settle_end;
  logic                        start_c, busy_c;

  assign start_run  = bus.go && (state == ST_IDLE || state == ST_REPORT);
  assign cap_now    = (state == ST_RUN) ? (bus.ch_done & ~captured) : '0;
  assign all_done   = &(captured | cap_now);
  // A capture on the last allowed cycle keeps the run alive one more edge so it is not lost.
  assign tmo_end    = !all_done && ((cyc == TO_LAST && cap_now == '0) || cyc == TO_VAL);
  assign settle_end = (state == ST_SETTLE) && (settle_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.go) state_nxt = ST_RUN;
      ST_RUN:    if (all_done || tmo_end) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_REPORT;
      ST_REPORT: if (bus.go) state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_c = (state == ST_RUN);
    busy_c  = (state == ST_RUN) || (state == ST_SETTLE);
  end

  // Lowest latency among completed channels; strict compare keeps ties on the lowest index.
  always_comb begin
    best_idx   = '0;
    best_val   = '0;
    best_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!tmo_q[i] && (!best_found || cycles_q[i*CNT_WIDTH +: CNT_WIDTH] < best_val)) begin
        best_idx   = IDX_WIDTH'(i);
        best_val   = cycles_q[i*CNT_WIDTH +: CNT_WIDTH];
        best_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      cyc        <= '0;
      settle_cnt <= '0;
      captured   <= '0;
      fail_q     <= '0;
      tmo_q      <= '0;
      cycles_q   <= '0;
      fidx_q     <= '0;
      fval_q     <= 1'b0;
      pass_q     <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      if (state == ST_RUN) begin
        if (cyc != TO_VAL) cyc <= cyc + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (cap_now[i]) begin
            cycles_q[i*CNT_WIDTH +: CNT_WIDTH] <= cyc;
            fail_q[i]   <= bus.ch_error[i];
            captured[i] <= 1'b1;
          end else if (tmo_end && !captured[i]) begin
            cycles_q[i*CNT_WIDTH +: CNT_WIDTH] <= TO_VAL;
            fail_q[i] <= 1'b0;
            tmo_q[i]  <= 1'b1;
          end
        end
        if (all_done || tmo_end) settle_cnt <= SETTLE_LOAD;
      end
      if (state == ST_SETTLE) begin
        if (settle_end) begin
          rv_q   <= 1'b1;
          fval_q <= best_found;
          fidx_q <= best_found ? best_idx : '0;
          pass_q <= (fail_q == '0) && (tmo_q == '0);
        end else begin
          settle_cnt <= settle_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.ch_start      = {NUM_CH{start_c}};
  assign bus.busy          = busy_c;
  assign bus.ch_cycles     = cycles_q;
  assign bus.ch_fail       = fail_q;
  assign bus.ch_timeout    = tmo_q;
  assign bus.fastest_idx   = fidx_q;
  assign bus.fastest_valid = fval_q;
  assign bus.all_pass      = pass_q;
  assign bus.report_valid  = rv_q;

endmodule

// File: tb/tb_bist_race_monitor.sv
// Bench for bist_race_monitor: directed vector table, reset/ignore sequences,
// then randomized races checked against a per-channel arithmetic model.
module tb_bist_race_monitor;
  localparam int NUM_CH    = 2;
  localparam int CNT_WIDTH = 16;
  localparam int TIMEOUT   = 100;
  localparam int SETTLE    = 10;
  localparam int IDX_WIDTH = 1;

  typedef struct {
    int       d0, d1;     // run cycle at which done rises, -1 = never
    bit [1:0] err;        // error level at the done cycle
    int       c0, c1;
    bit [1:0] fail, tmo;
    bit       fidx, fval, ap;
    int       end_k;      // run cycle whose closing edge ends RUN
  } vec_t;

  logic clk = 0;
  logic rst = 1;
  int   n_checks = 0;
  int   n_pass   = 0;

  bist_race_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  bist_race_monitor #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT),
    .SETTLE(SETTLE), .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   d[2];
    int   c[2];
    bit   cap[2];
    int   best = -1;
    int   last = 0;
    d[0] = v.d0;
    d[1] = v.d1;
    for (int i = 0; i < 2; i++) begin
      cap[i]    = (d[i] >= 0) && (d[i] <= TIMEOUT - 1);
      c[i]      = cap[i] ? d[i] : TIMEOUT;
      r.fail[i] = cap[i] && v.err[i];
      r.tmo[i]  = !cap[i];
      if (cap[i] && d[i] > last) last = d[i];
      if (cap[i] && (best < 0 || c[i] < c[best])) best = i;
    end
    r.c0    = c[0];
    r.c1    = c[1];
    r.fval  = (best >= 0);
    r.fidx  = (best > 0);
    r.ap    = (r.fail == 0) && (r.tmo == 0);
    r.end_k = (cap[0] && cap[1]) ? last : TIMEOUT - 1;
    return r;
  endfunction

  task automatic do_run(input vec_t v, input string tag);
    int end_k = -1;
    int settle_n = 0;
    bit [1:0] dn;
    bus.go = 1;
    tick();
    bus.go = 0;
    check({tag, " cleared_rv"}, bus.report_valid, 0);
    check({tag, " cleared_cycles"}, bus.ch_cycles, 0);
    check({tag, " cleared_flags"}, {bus.ch_fail, bus.ch_timeout, bus.fastest_valid, bus.all_pass}, 0);
    check({tag, " start_busy"}, {bus.ch_start, bus.busy}, 3'b111);
    for (int k = 0; k < TIMEOUT + 5; k++) begin
      dn[0] = (v.d0 >= 0) && (k >= v.d0);
      dn[1] = (v.d1 >= 0) && (k >= v.d1);
      bus.ch_done     = dn;
      bus.ch_error[0] = (k == v.d0) ? v.err[0] : 1'($urandom_range(0, 1));
      bus.ch_error[1] = (k == v.d1) ? v.err[1] : 1'($urandom_range(0, 1));
      bus.go          = ($urandom_range(0, 5) == 0);
      tick();
      if (bus.ch_start == 0) begin
        end_k = k;
        break;
      end
    end
    check({tag, " end_edge"}, end_k, v.end_k);
    while (!bus.report_valid && settle_n < SETTLE + 5) begin
      bus.go       = ($urandom_range(0, 3) == 0);
      bus.ch_error = 2'($urandom_range(0, 3));
      tick();
      settle_n++;
    end
    bus.go = 0;
    check({tag, " settle_len"}, settle_n, SETTLE);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " cycles0"}, bus.ch_cycles[15:0], v.c0);
    check({tag, " cycles1"}, bus.ch_cycles[31:16], v.c1);
    check({tag, " fail"}, bus.ch_fail, v.fail);
    check({tag, " timeout"}, bus.ch_timeout, v.tmo);
    check({tag, " fastest_idx"}, bus.fastest_idx, v.fidx);
    check({tag, " fastest_valid"}, bus.fastest_valid, v.fval);
    check({tag, " all_pass"}, bus.all_pass, v.ap);
    bus.ch_done  = 0;
    bus.ch_error = 0;
    tick();
    check({tag, " report_hold"}, {bus.report_valid, bus.ch_cycles[15:0]}, {1'b1, 16'(v.c0)});
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{37, 52, 2'b00, 37, 52, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 52};
    tbl[1] = '{37, 52, 2'b10, 37, 52, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 52};
    tbl[2] = '{20, -1, 2'b00, 20, 100, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 99};
    tbl[3] = '{-1, -1, 2'b11, 100, 100, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 99};
    tbl[4] = '{40, 40, 2'b00, 40, 40, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 40};
    tbl[5] = '{60, 15, 2'b01, 60, 15, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 60};
    tbl[6] = '{0, 99, 2'b00, 0, 99, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 99};

    bus.go = 0;
    bus.ch_done = 0;
    bus.ch_error = 0;
    rst = 1;
    repeat (3) tick();
    check("reset_outputs",
          {bus.ch_start, bus.ch_cycles, bus.ch_fail, bus.ch_timeout, bus.fastest_idx,
           bus.fastest_valid, bus.all_pass, bus.busy, bus.report_valid}, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 7; i++) do_run(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a run: starts drop, no report, late dones ignored.
    bus.go = 1;
    tick();
    bus.go = 0;
    repeat (15) tick();
    rst = 1;
    tick();
    rst = 0;
    check("midrst_outputs", {bus.ch_start, bus.busy, bus.report_valid}, 0);
    bus.ch_done = 2'b11;
    repeat (30) tick();
    check("midrst_ignored", {bus.busy, bus.report_valid, bus.ch_cycles}, 0);
    bus.ch_done = 0;
    tick();
    do_run(tbl[0], "after_rst");

    for (int n = 0; n < 40; n++) begin
      rv.d0  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 2));
      rv.d1  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 2));
      if ($urandom_range(0, 4) == 0) rv.d1 = rv.d0;
      rv.err = 2'($urandom_range(0, 3));
      rv = model(rv);
      do_run(rv, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bist_race_monitor.md
Name: bist_race_monitor

Overview:
- Synthesizable, parametrised successor to the bench-level BIST latency/status comparison.
- Launches NUM_CH BIST engines (e.g. BICS and STRAIT variants) with a common start, and measures each engine's completion latency in cycles.
- Latches each engine's error status at completion, applies a hardware watchdog, and after a settle window presents a registered report: per-channel cycles, fail and timeout flags, fastest channel, and overall pass.

Parameters:
- NUM_CH, 2, number of BIST channels raced (>=1).
- CNT_WIDTH, 16, width of each latency counter/result; must satisfy 2^CNT_WIDTH > TIMEOUT.
- TIMEOUT, 5000, run cycles allowed before unfinished channels are declared timed out (>=2).
- SETTLE, 10, cycles between run end and report_valid (>=1).
- IDX_WIDTH, 1, width of fastest_idx; must satisfy 2^IDX_WIDTH >= NUM_CH.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- go  in  1  run request; sampled in IDLE or REPORT.
- ch_start  out  NUM_CH  per-channel start level to the BIST engines.
- ch_done  in  NUM_CH  per-channel done, level.
- ch_error  in  NUM_CH  per-channel error, sampled with done.
- ch_cycles  out  NUM_CH*CNT_WIDTH  latched latency; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- ch_fail  out  NUM_CH  error latched at completion.
- ch_timeout  out  NUM_CH  channel never completed within TIMEOUT.
- fastest_idx  out  IDX_WIDTH  index of the lowest-latency completed channel.
- fastest_valid  out  1  at least one channel completed.
- all_pass  out  1  no fail and no timeout on any channel.
- busy  out  1  high in RUN and SETTLE.
- report_valid  out  1  results stable and valid.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and captured flags cleared. Reset mid-operation has the same effect at the next edge: ch_start drops and no report is produced.
- FSM states: IDLE, RUN, SETTLE, REPORT.
- IDLE -> RUN on go=1:
  - At that edge: clear cyc, ch_cycles, ch_fail, ch_timeout, the captured mask, fastest_*, all_pass, report_valid.
  - ch_start = all ones from the first RUN cycle.
- RUN:
  - cyc = 0 in the first RUN cycle; cyc increments by 1 per cycle.
  - For each channel i not yet captured with ch_done[i]=1 at the edge: ch_cycles[i] <= cyc, ch_fail[i] <= ch_error[i], and captured[i] is set.
  - Captured channels ignore any further done/error activity.
  - A done already high in the first RUN cycle captures 0.
  - Several channels completing on the same edge are all captured on that edge.
  - All channels captured (including on the current edge) -> SETTLE.
  - Otherwise, when cyc = TIMEOUT-1 and no capture occurs that edge -> SETTLE; every uncaptured channel gets ch_timeout=1, ch_cycles=TIMEOUT, ch_fail=0.
  - go is ignored while in RUN.
- SETTLE:
  - ch_start = 0.
  - Wait exactly SETTLE cycles, then -> REPORT.
  - go is ignored.
- Entry to REPORT (registered):
  - report_valid = 1.
  - fastest_idx = the non-timeout channel with minimum ch_cycles; ties go to the lowest index.
  - fastest_valid = 1 if any channel did not time out; if fastest_valid = 0, fastest_idx = 0.
  - all_pass = 1 iff ch_fail and ch_timeout are both all zero.
- REPORT:
  - Outputs hold until go=1, which starts a new run directly (same actions as IDLE -> RUN; report_valid drops at that edge).
  - busy = 0.
- cyc never exceeds TIMEOUT; there is no wrap-around.

Test Plan:
- NUM_CH=2: ch_done[0] rises 37 cycles after ch_start, ch_done[1] after 52, errors 0 -> ch_cycles={52,37}, fastest_idx=0, fastest_valid=1, all_pass=1, report_valid 1 exactly SETTLE cycles after the ch1 capture edge.
- Same run with ch_error[1]=1 at its done -> ch_fail=2'b10, all_pass=0, fastest_idx=0; pulsing ch_error[0] after ch0 is captured changes nothing.
- TIMEOUT=100, ch1 never done, ch0 done at 20 -> ch_timeout=2'b10, ch_cycles[1]=100, ch_cycles[0]=20, fastest_idx=0, all_pass=0; neither channel done -> fastest_valid=0, fastest_idx=0.
- Both channels done on the same edge at 40 -> both captured with 40, fastest_idx=0 (tie), transition to SETTLE on that edge.
- rst asserted at run cycle 15 -> next edge: ch_start=0, busy=0, report_valid=0; ch_done arriving later is ignored until the next go.
- go pulsed during RUN and SETTLE is ignored; go in REPORT -> new run starts, previous results cleared, second report matches the second stimulus.
